// File: rtl/hist_peak_builder.sv
// hist_peak_builder
//   Per-pixel coarse-bin histogram builder for the dToF pipeline. Timestamps arrive
//   interleaved pixel by pixel; after ACQ_NUM acquisitions each pixel's peak bin is
//   streamed out on a valid/ready port, then the histogram memory is cleared again.
//   Optional feature macro: HIST_PEAK_CNT_EN adds out_cnt (peak count of out_pixel).
module hist_peak_builder #(
   parameter int TS_W      = 10,
   parameter int BIN_W     = 6,
   parameter int PIXEL_NUM = 6,
   parameter int ACQ_NUM   = 2,
   parameter int CNT_W     = 8,
   localparam int PIX_W    = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [TS_W-1:0]  data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic [BIN_W-1:0] out_bin,
`ifdef HIST_PEAK_CNT_EN
   output logic [CNT_W-1:0] out_cnt,
`endif
   output logic             frame_done,
   output logic             drop_err
);

   localparam int ACQ_W  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
   localparam int ADDR_W = PIX_W + BIN_W;
   localparam int DEPTH  = PIXEL_NUM * (2 ** BIN_W);

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIXEL_NUM - 1);
   localparam logic [ACQ_W-1:0]  ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] clrAddr;
   logic [PIX_W-1:0]  pixCnt;
   logic [ACQ_W-1:0]  acqCnt;

   logic              s0Vld;
   logic              s0Last;
   logic [PIX_W-1:0]  s0Pix;
   logic [BIN_W-1:0]  s0Bin;
   logic [CNT_W-1:0]  s0Rd;

   logic              s1Vld;
   logic              s1Last;
   logic [PIX_W-1:0]  s1Pix;
   logic [BIN_W-1:0]  s1Bin;
   logic [CNT_W-1:0]  s1Old;
   logic [CNT_W-1:0]  s1New;

   logic [CNT_W-1:0]  histMem [DEPTH];
   logic [CNT_W-1:0]  maxCnt  [PIXEL_NUM];
   logic [BIN_W-1:0]  maxBin  [PIXEL_NUM];

   logic              accept;
   logic              lastAccept;
   logic              unusedData;

   assign accept     = wr_en && in_ready;
   assign lastAccept = accept && (pixCnt == PIX_LAST) && (acqCnt == ACQ_LAST);
   // Only the top BIN_W bits select a bin; the fine bits are intentionally dropped.
   assign unusedData = ^data;

   // Saturating increment in S1 and S0 read with same-address forwarding from S1
   always_comb begin
      s1New = (s1Old == CNT_MAX) ? s1Old : s1Old + 1'b1;
      if (s1Vld && (s1Pix == s0Pix) && (s1Bin == s0Bin))
         s0Rd = s1New;
      else
         s0Rd = histMem[{s0Pix, s0Bin}];
   end

   // Two-stage read-modify-write pipeline registers
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         s0Vld  <= 1'b0;
         s0Last <= 1'b0;
         s0Pix  <= '0;
         s0Bin  <= '0;
         s1Vld  <= 1'b0;
         s1Last <= 1'b0;
         s1Pix  <= '0;
         s1Bin  <= '0;
         s1Old  <= '0;
      end else begin
         s0Vld  <= accept;
         s0Last <= lastAccept;
         if (accept) begin
            s0Pix <= pixCnt;
            s0Bin <= data[TS_W-1 -: BIN_W];
         end
         s1Vld  <= s0Vld;
         s1Last <= s0Vld && s0Last;
         if (s0Vld) begin
            s1Pix <= s0Pix;
            s1Bin <= s0Bin;
            s1Old <= s0Rd;
         end
      end
   end

   // Histogram memory: one word zeroed per CLEAR cycle, S1 write-back during ACCUM
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         histMem[clrAddr] <= '0;
      else if (s1Vld)
         histMem[{s1Pix, s1Bin}] <= s1New;
   end

   // Per-pixel peak tracking; strict compare keeps the bin that reached a count first
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         for (int unsigned i = 0; i < PIXEL_NUM; i++) begin
            maxCnt[i] <= '0;
            maxBin[i] <= '0;
         end
      end else if (s1Vld && (s1New > maxCnt[s1Pix])) begin
         maxCnt[s1Pix] <= s1New;
         maxBin[s1Pix] <= s1Bin;
      end
   end

   // Frame control: clear sweep, sample acceptance, result drain
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= CLEAR;
         clrAddr    <= '0;
         pixCnt     <= '0;
         acqCnt     <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_pixel  <= '0;
         out_bin    <= '0;
`ifdef HIST_PEAK_CNT_EN
         out_cnt    <= '0;
`endif
         frame_done <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (wr_en && !in_ready)
            drop_err <= 1'b1;
         case (state)
            CLEAR: begin
               clrAddr <= clrAddr + 1'b1;
               if (clrAddr == CLR_LAST) begin
                  state    <= ACCUM;
                  in_ready <= 1'b1;
                  pixCnt   <= '0;
                  acqCnt   <= '0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  if (pixCnt == PIX_LAST) begin
                     pixCnt <= '0;
                     acqCnt <= acqCnt + 1'b1;
                  end else begin
                     pixCnt <= pixCnt + 1'b1;
                  end
               end
               if (lastAccept)
                  in_ready <= 1'b0;
               if (s1Vld && s1Last) begin
                  state     <= DRAIN;
                  out_pixel <= '0;
               end
            end
            DRAIN: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_bin   <= maxBin[out_pixel];
`ifdef HIST_PEAK_CNT_EN
                  out_cnt   <= maxCnt[out_pixel];
`endif
               end else if (out_ready) begin
                  if (out_pixel == PIX_LAST) begin
                     out_valid  <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= CLEAR;
                     clrAddr    <= '0;
                  end else begin
                     out_pixel <= out_pixel + 1'b1;
                     out_bin   <= maxBin[out_pixel + 1'b1];
`ifdef HIST_PEAK_CNT_EN
                     out_cnt   <= maxCnt[out_pixel + 1'b1];
`endif
                  end
               end
            end
            default: begin
               state   <= CLEAR;
               clrAddr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hist_peak_builder.sv
// tb_hist_peak_builder
//   Two instances: A (6 pixels x 2 acquisitions) and B (1 pixel x 300 acquisitions).
//   Frame vectors come from a table or from a small histogram model; expected peaks
//   are queued when a frame is driven and popped as results are handshaken.
module tb_hist_peak_builder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       res;

   logic       wrA, inRdyA, oValA, oRdyA, fdA, deA;
   logic [9:0] dA;
   logic [2:0] pixA;
   logic [5:0] binA;

   logic       wrB, inRdyB, oValB, oRdyB, fdB, deB;
   logic [9:0] dB;
   logic [0:0] pixB;
   logic [5:0] binB;
`ifdef HIST_PEAK_CNT_EN
   logic [7:0] cntA, cntB;
`endif

   hist_peak_builder #(.TS_W(10), .BIN_W(6), .PIXEL_NUM(6), .ACQ_NUM(2), .CNT_W(8)) dutA (
      .clk(clk), .res(res), .wr_en(wrA), .data(dA), .in_ready(inRdyA),
      .out_valid(oValA), .out_ready(oRdyA), .out_pixel(pixA), .out_bin(binA),
`ifdef HIST_PEAK_CNT_EN
      .out_cnt(cntA),
`endif
      .frame_done(fdA), .drop_err(deA));

   hist_peak_builder #(.TS_W(10), .BIN_W(6), .PIXEL_NUM(1), .ACQ_NUM(300), .CNT_W(8)) dutB (
      .clk(clk), .res(res), .wr_en(wrB), .data(dB), .in_ready(inRdyB),
      .out_valid(oValB), .out_ready(oRdyB), .out_pixel(pixB), .out_bin(binB),
`ifdef HIST_PEAK_CNT_EN
      .out_cnt(cntB),
`endif
      .frame_done(fdB), .drop_err(deB));

   typedef struct {
      logic [2:0] pix;
      logic [5:0] bin;
      logic [7:0] cnt;
   } expT;

   typedef struct {
      logic [11:0][9:0] d;
      logic [5:0][5:0]  bin;
      logic [5:0][7:0]  cnt;
      int               gap;
      int               stall;
   } vecT;

   expT sbA[$];
   vecT vecs[4];
   int  checks   = 0;
   int  failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic fillVec(input int idx, input logic [9:0] dv[12], input logic [5:0] bv[6],
                          input logic [7:0] cv[6], input int gap, input int stall);
      for (int k = 0; k < 12; k++) vecs[idx].d[k] = dv[k];
      for (int p = 0; p < 6; p++) begin
         vecs[idx].bin[p] = bv[p];
         vecs[idx].cnt[p] = cv[p];
      end
      vecs[idx].gap   = gap;
      vecs[idx].stall = stall;
   endtask

   // Reference histogram: strict-greater update in arrival order
   task automatic modelVec(input int idx);
      for (int p = 0; p < 6; p++) begin
         int h[64];
         int mx;
         int mb;
         int b;
         for (int i = 0; i < 64; i++) h[i] = 0;
         mx = 0;
         mb = 0;
         for (int a = 0; a < 2; a++) begin
            b = int'(vecs[idx].d[a*6+p]) / 16;
            h[b]++;
            if (h[b] > mx) begin
               mx = h[b];
               mb = b;
            end
         end
         vecs[idx].bin[p] = 6'(mb);
         vecs[idx].cnt[p] = 8'(mx);
      end
   endtask

   task automatic waitReadyA();
      int n = 0;
      while (!inRdyA && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("A_in_ready_wait", inRdyA, 1);
   endtask

   task automatic collectA(input int stall);
      expT e;
      for (int i = 0; i < 6; i++) begin
         int n = 0;
         while (!oValA && n < 200) begin
            @(posedge clk); #1; n++;
         end
         if (!oValA) begin
            chk("A_out_valid_wait", oValA, 1);
            return;
         end
         if (sbA.size() == 0) begin
            chk("A_scoreboard_underflow", 0, 1);
            return;
         end
         e = sbA.pop_front();
         chk("A_out_pixel", pixA, e.pix);
         chk("A_out_bin", binA, e.bin);
`ifdef HIST_PEAK_CNT_EN
         chk("A_out_cnt", cntA, e.cnt);
`endif
         if (i == 0) begin
            for (int s = 0; s < stall; s++) begin
               @(posedge clk); #1;
               chk("A_stall_valid", oValA, 1);
               chk("A_stall_pixel", pixA, e.pix);
               chk("A_stall_bin", binA, e.bin);
            end
         end
         oRdyA = 1'b1;
         @(posedge clk); #1;
         oRdyA = 1'b0;
         if (i == 5) begin
            chk("A_frame_done", fdA, 1);
            chk("A_valid_after_last", oValA, 0);
         end
      end
   endtask

   task automatic runFrameA(input int idx, input bit holdWr);
      waitReadyA();
      for (int p = 0; p < 6; p++)
         sbA.push_back('{pix: 3'(p), bin: vecs[idx].bin[p], cnt: vecs[idx].cnt[p]});
      for (int k = 0; k < 12; k++) begin
         wrA = 1'b1;
         dA  = vecs[idx].d[k];
         @(posedge clk); #1;
         if (vecs[idx].gap != 0) begin
            wrA = 1'b0;
            @(posedge clk); #1;
         end
      end
      chk("A_in_ready_drop", inRdyA, 0);
      wrA = holdWr;
      dA  = 10'd1023;
      collectA(vecs[idx].stall);
      wrA = 1'b0;
      if (holdWr) chk("A_drop_err_set", deA, 1);
   endtask

   task automatic runFrameB(input int nSame, input logic [9:0] dSame, input int nAlt,
                            input logic [5:0] expBin, input logic [7:0] expCnt);
      int n = 0;
      while (!inRdyB && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      chk("B_in_ready_wait", inRdyB, 1);
      for (int k = 0; k < nSame + nAlt; k++) begin
         wrB = 1'b1;
         if (k < nSame) dB = dSame;
         else dB = (k[0]) ? 10'd336 : 10'd320;
         @(posedge clk); #1;
      end
      wrB = 1'b0;
      chk("B_in_ready_drop", inRdyB, 0);
      n = 0;
      while (!oValB && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("B_out_valid", oValB, 1);
      chk("B_out_pixel", pixB, 0);
      chk("B_out_bin", binB, expBin);
`ifdef HIST_PEAK_CNT_EN
      chk("B_out_cnt", cntB, expCnt);
`else
      if (expCnt == 8'd0) chk("B_expected_cnt_nonzero", expCnt, 1);
`endif
      oRdyB = 1'b1;
      @(posedge clk); #1;
      oRdyB = 1'b0;
      chk("B_frame_done", fdB, 1);
      chk("B_valid_after_last", oValB, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] dv[12];
      logic [5:0] bv[6];
      logic [7:0] cv[6];
      int nA, nB;

      res = 1'b0;
      wrA = 1'b0; dA = '0; oRdyA = 1'b0;
      wrB = 1'b0; dB = '0; oRdyB = 1'b0;

      // vector 0: every sample in bin 6
      for (int k = 0; k < 12; k++) dv[k] = 10'd108;
      for (int p = 0; p < 6; p++) begin bv[p] = 6'd6; cv[p] = 8'd2; end
      fillVec(0, dv, bv, cv, 0, 0);
      // vector 1: ties resolved to first arrival, pixel 0 stalled downstream
      dv = '{10'd511, 10'd16, 10'd32, 10'd1023, 10'd0, 10'd200,
             10'd1022, 10'd16, 10'd48, 10'd1023, 10'd15, 10'd100};
      bv = '{6'd31, 6'd1, 6'd2, 6'd63, 6'd0, 6'd12};
      cv = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd1};
      fillVec(1, dv, bv, cv, 0, 5);
      // vector 2: idle cycles between samples
      dv = '{10'd0, 10'd1000, 10'd500, 10'd250, 10'd125, 10'd64,
             10'd0, 10'd1000, 10'd501, 10'd260, 10'd126, 10'd127};
      bv = '{6'd0, 6'd62, 6'd31, 6'd15, 6'd7, 6'd4};
      cv = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd2, 8'd1};
      fillVec(2, dv, bv, cv, 1, 0);

      repeat (3) @(posedge clk);
      #1;
      res = 1'b1;
      chk("A_reset_in_ready", inRdyA, 0);
      chk("A_reset_out_valid", oValA, 0);
      chk("A_reset_out_pixel", pixA, 0);
      chk("A_reset_out_bin", binA, 0);
      chk("A_reset_frame_done", fdA, 0);
      chk("A_reset_drop_err", deA, 0);
      chk("B_reset_out_valid", oValB, 0);

      nA = 0; nB = 0;
      for (int c = 1; c <= 1000; c++) begin
         @(posedge clk); #1;
         if (inRdyB && nB == 0) nB = c;
         if (inRdyA && nA == 0) nA = c;
         if (nA != 0 && nB != 0) break;
      end
      chk("A_clear_cycles", nA, 384);
      chk("B_clear_cycles", nB, 64);

      runFrameA(0, 1'b0);
      runFrameA(1, 1'b0);
      runFrameA(2, 1'b0);
      chk("A_drop_err_clean", deA, 0);

      runFrameA(0, 1'b1);
      runFrameA(2, 1'b0);

      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 12; k++) vecs[3].d[k] = 10'($urandom_range(0, 127));
         vecs[3].gap   = r;
         vecs[3].stall = 2;
         modelVec(3);
         runFrameA(3, 1'b0);
      end

      // abort a frame partway through accumulation
      waitReadyA();
      for (int k = 0; k < 5; k++) begin
         wrA = 1'b1;
         dA  = 10'd1023;
         @(posedge clk); #1;
      end
      wrA = 1'b0;
      res = 1'b0;
      #2;
      chk("A_midreset_in_ready", inRdyA, 0);
      chk("A_midreset_out_valid", oValA, 0);
      chk("A_midreset_drop_err", deA, 0);
      @(posedge clk); #1;
      res = 1'b1;
      runFrameA(1, 1'b0);

      runFrameB(300, 10'd1023, 0, 6'd63, 8'd255);
      runFrameB(120, 10'd160, 180, 6'd10, 8'd120);
      chk("B_drop_err_clean", deB, 0);

      chk("A_scoreboard_empty", sbA.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
